// File: rtl/inst_fetch_bridge_if.sv
// Fetch bridge bundle: core-side ROM port plus the req/ack port toward instruction memory.
// The bridge takes the slave view; whoever drives the core and memory sides takes the master view.
interface inst_fetch_bridge_if;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        stallreq_from_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    modport slave (
        input  rom_ce_i, rom_addr_i, mem_ack_i, mem_rdata_i,
        output rom_data_o, stallreq_from_if, mem_req_o, mem_addr_o, err_o
    );

    modport master (
        output rom_ce_i, rom_addr_i, mem_ack_i, mem_rdata_i,
        input  rom_data_o, stallreq_from_if, mem_req_o, mem_addr_o, err_o
    );
endinterface

// File: rtl/inst_fetch_bridge.sv
// One-entry instruction fetch buffer bridging the core's same-cycle ROM port to a
// variable-latency req/ack instruction memory, stalling the core until the word is present.
//
//   state | meaning
//   IDLE  | no request outstanding; a miss launches one
//   REQ   | request held on the memory port until ack or timeout
module inst_fetch_bridge #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_bridge_if.slave bus
);

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state;
    logic               buf_valid;
    logic [29:0]        buf_tag;
    logic [31:0]        buf_data;
    logic [CNT_W-1:0]   wait_cnt;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic               err;
    logic               hit;
    logic               stall;

    assign hit   = bus.rom_ce_i & buf_valid & (buf_tag == bus.rom_addr_i[31:2]);
    assign stall = bus.rom_ce_i & ~hit;

    assign bus.rom_data_o       = hit ? buf_data : 32'h0;
    assign bus.stallreq_from_if = stall;
    assign bus.mem_req_o        = mem_req;
    assign bus.mem_addr_o       = mem_addr;
    assign bus.err_o            = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= {bus.rom_addr_i[31:2], 2'b00};
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    // An ack in the timeout cycle still delivers real data.
                    if (bus.mem_ack_i) begin
                        buf_tag   <= mem_addr[31:2];
                        buf_data  <= bus.mem_rdata_i;
                        buf_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= IDLE;
                    end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                        buf_tag   <= mem_addr[31:2];
                        buf_data  <= 32'h0;
                        buf_valid <= 1'b1;
                        err       <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
